// File: rtl/uart_tx_mmio.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_mmio
// Purpose  : Memory-mapped 8N1 UART transmitter with TX FIFO and baud divider.
//            Optional CTRL register / TX-empty interrupt under UART_TX_IRQ_EN.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_mmio #(
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_RESET  = 868
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        system_bus_en,
    input  logic        system_bus_rdwr,
    input  logic [31:0] system_bus_addr,
    input  logic [31:0] system_bus_wr_data,
    input  logic [3:0]  system_bus_mask,
    output logic [31:0] system_bus_rd_data,
    output logic        tx,
    output logic        irq
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [CW-1:0] c_full_count = CW'(FIFO_DEPTH);
    localparam logic [15:0]   c_div_reset  = 16'(DIV_RESET);
    localparam logic [15:0]   c_div_min    = 16'd2;
    localparam logic [1:0]    c_reg_txdata = 2'd0;
    localparam logic [1:0]    c_reg_status = 2'd1;
    localparam logic [1:0]    c_reg_baud   = 2'd2;
    localparam logic [1:0]    c_reg_ctrl   = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t        state_q;
    logic [15:0]   timer_q;
    logic [7:0]    shift_q;
    logic [2:0]    bit_cnt_q;
    logic          tx_q;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic [15:0]   baud_div_q, baud_div_d;
    logic [31:0]   rd_data_q, rd_data_d;

    logic [1:0]    w_reg;
    logic          w_wr, w_rd, w_push, w_pop, w_push_ok;
    logic          w_full, w_empty, w_busy, w_bit_end;
    logic [7:0]    w_head;
    logic [31:0]   w_status;
    logic [31:0]   w_ctrl_rd;
    logic [15:0]   w_baud_new;

    assign w_reg     = system_bus_addr[3:2];
    assign w_wr      = system_bus_en &  system_bus_rdwr;
    assign w_rd      = system_bus_en & ~system_bus_rdwr;
    assign w_push    = w_wr && (w_reg == c_reg_txdata) && system_bus_mask[0];
    assign w_full    = (count_q == c_full_count);
    assign w_empty   = (count_q == '0);
    assign w_busy    = (state_q != S_IDLE);
    assign w_bit_end = (timer_q == 16'd1);
    // The FSM takes a byte when idle, or at the last clock of a stop bit so frames abut.
    assign w_pop     = !w_empty && ((state_q == S_IDLE) || ((state_q == S_STOP) && w_bit_end));
    assign w_push_ok = w_push && (!w_full || w_pop);
    assign w_head    = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
        if (w_pop)     rd_ptr_d = rd_ptr_q + PW'(1);
        if (w_push_ok && !w_pop)      count_d = count_q + CW'(1);
        else if (!w_push_ok && w_pop) count_d = count_q - CW'(1);
    end

    always_comb begin
        overflow_d = overflow_q;
        if (w_push && !w_push_ok)
            overflow_d = 1'b1;
        else if (w_wr && (w_reg == c_reg_status) && system_bus_mask[0] && system_bus_wr_data[3])
            overflow_d = 1'b0;
    end

    always_comb begin
        w_baud_new = baud_div_q;
        if (system_bus_mask[0]) w_baud_new[7:0]  = system_bus_wr_data[7:0];
        if (system_bus_mask[1]) w_baud_new[15:8] = system_bus_wr_data[15:8];
        baud_div_d = baud_div_q;
        if (w_wr && (w_reg == c_reg_baud))
            baud_div_d = (w_baud_new < c_div_min) ? c_div_min : w_baud_new;
    end

    always_comb begin
        w_status         = '0;
        w_status[0]      = w_full;
        w_status[1]      = w_empty;
        w_status[2]      = w_busy;
        w_status[3]      = overflow_q;
        w_status[8 +: CW] = count_q;
    end

    always_comb begin
        rd_data_d = rd_data_q;
        if (w_rd) begin
            case (w_reg)
                c_reg_txdata: rd_data_d = '0;
                c_reg_status: rd_data_d = w_status;
                c_reg_baud:   rd_data_d = {16'd0, baud_div_q};
                default:      rd_data_d = w_ctrl_rd;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            baud_div_q <= c_div_reset;
            rd_data_q  <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            baud_div_q <= baud_div_d;
            rd_data_q  <= rd_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) mem_q[wr_ptr_q] <= system_bus_wr_data[7:0];
    end

    // Every bit boundary reloads the timer, so a new divider applies from the next bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            timer_q   <= c_div_reset;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            tx_q      <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (w_pop) begin
                        state_q <= S_START;
                        shift_q <= w_head;
                        timer_q <= baud_div_q;
                        tx_q    <= 1'b0;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        state_q   <= S_DATA;
                        tx_q      <= shift_q[0];
                        shift_q   <= {1'b0, shift_q[7:1]};
                        bit_cnt_q <= '0;
                        timer_q   <= baud_div_q;
                    end else begin
                        timer_q <= timer_q - 16'd1;
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        timer_q <= baud_div_q;
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= S_STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            tx_q      <= shift_q[0];
                            shift_q   <= {1'b0, shift_q[7:1]};
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                        end
                    end else begin
                        timer_q <= timer_q - 16'd1;
                    end
                end
                default: begin
                    if (w_bit_end) begin
                        if (w_pop) begin
                            state_q <= S_START;
                            shift_q <= w_head;
                            timer_q <= baud_div_q;
                            tx_q    <= 1'b0;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end else begin
                        timer_q <= timer_q - 16'd1;
                    end
                end
            endcase
        end
    end

`ifdef UART_TX_IRQ_EN
    logic irq_en_q, irq_en_d;
    logic irq_q, irq_d;

    always_comb begin
        irq_en_d = irq_en_q;
        if (w_wr && (w_reg == c_reg_ctrl) && system_bus_mask[0])
            irq_en_d = system_bus_wr_data[0];
        irq_d = irq_en_q && w_empty && !w_busy;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
            irq_q    <= irq_d;
        end
    end

    assign irq       = irq_q;
    assign w_ctrl_rd = {31'd0, irq_en_q};
`else
    assign irq       = 1'b0;
    assign w_ctrl_rd = '0;
`endif

    logic unused_bus_bits;
    assign unused_bus_bits = ^{system_bus_addr[31:4], system_bus_addr[1:0],
                               system_bus_mask[3:2], system_bus_wr_data[31:16]};

    assign tx                 = tx_q;
    assign system_bus_rd_data = rd_data_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_mmio.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_mmio
// Purpose  : Self-checking bench for uart_tx_mmio; a line receiver decodes tx.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_mmio;

    localparam int DEPTH = 16;
    localparam int DIV0  = 868;

    logic        clk;
    logic        rst;
    logic        bus_en;
    logic        bus_rdwr;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_mask;
    logic [31:0] bus_rdata;
    logic        tx;
    logic        irq;

    int n_tests;
    int n_fail;
    int cyc;
    int div_model;
    bit mon_en;
    logic [7:0] rx_data [$];
    int         rx_start [$];
    int         rx_bad;

    uart_tx_mmio #(.FIFO_DEPTH(DEPTH), .DIV_RESET(DIV0)) dut (
        .clk                (clk),
        .rst                (rst),
        .system_bus_en      (bus_en),
        .system_bus_rdwr    (bus_rdwr),
        .system_bus_addr    (bus_addr),
        .system_bus_wr_data (bus_wdata),
        .system_bus_mask    (bus_mask),
        .system_bus_rd_data (bus_rdata),
        .tx                 (tx),
        .irq                (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Line receiver: samples every cycle at the falling clock edge and decodes 8N1 frames.
    initial begin : line_monitor
        int d;
        int i;
        int pos;
        logic [7:0] b;
        bit bad;
        forever begin
            @(negedge clk);
            if (mon_en && tx === 1'b0) begin
                d = div_model;
                b = '0;
                bad = 1'b0;
                rx_start.push_back(cyc);
                i = 0;
                while (i < 10 * d && mon_en) begin
                    if (i > 0) @(negedge clk);
                    if (mon_en) begin
                        pos = i / d;
                        if (pos == 0) begin
                            if (tx !== 1'b0) bad = 1'b1;
                        end else if (pos == 9) begin
                            if (tx !== 1'b1) bad = 1'b1;
                        end else if (i % d == 0) begin
                            b[pos-1] = tx;
                        end else if (tx !== b[pos-1]) begin
                            bad = 1'b1;
                        end
                    end
                    i++;
                end
                if (mon_en) begin
                    rx_data.push_back(b);
                    if (bad) rx_bad++;
                end
            end
        end
    end

    function automatic logic [31:0] exp_status(input int cnt, input bit busy, input bit ovf);
        logic [31:0] s;
        s       = '0;
        s[0]    = (cnt == DEPTH);
        s[1]    = (cnt == 0);
        s[2]    = busy;
        s[3]    = ovf;
        s[14:8] = 7'(cnt);
        return s;
    endfunction

    function automatic int baud_after(input int old, input logic [31:0] d, input logic [3:0] m);
        int v;
        int lo;
        int hi;
        lo = int'(d[7:0]);
        hi = int'(d[15:8]);
        v  = old;
        if (m[0]) v = (v / 256) * 256 + lo;
        if (m[1]) v = (v % 256) + hi * 256;
        if (v < 2) v = 2;
        return v;
    endfunction

    task automatic bus_write(input logic [1:0] r, input logic [31:0] d, input logic [3:0] m);
        bus_en    = 1'b1;
        bus_rdwr  = 1'b1;
        bus_addr  = {4'b1010, 24'($urandom), r, 2'($urandom)};
        bus_wdata = d;
        bus_mask  = m;
        @(posedge clk); #1;
        bus_en    = 1'b0;
        bus_rdwr  = 1'b0;
        bus_wdata = $urandom;
        bus_mask  = 4'($urandom);
    endtask

    task automatic bus_read(input logic [1:0] r, output logic [31:0] d);
        bus_en   = 1'b1;
        bus_rdwr = 1'b0;
        bus_addr = {4'b1010, 24'($urandom), r, 2'($urandom)};
        @(posedge clk); #1;
        bus_en   = 1'b0;
        d        = bus_rdata;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) begin @(posedge clk); #1; end
    endtask

    task automatic wait_rx(input int n, input int budget, output bit ok);
        int k;
        k = 0;
        while (rx_data.size() < n && k < budget) begin @(posedge clk); #1; k++; end
        ok = (rx_data.size() >= n);
    endtask

    task automatic clear_mon();
        rx_data.delete();
        rx_start.delete();
        rx_bad = 0;
    endtask

    task automatic test_reset();
        logic [31:0] r;
        mon_en = 1'b0;
        bus_en = 1'b0; bus_rdwr = 1'b0; bus_addr = '0; bus_wdata = '0; bus_mask = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_tests++; if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b want 1", tx); end
        n_tests++; if (bus_rdata !== 32'd0) begin n_fail++; $display("FAIL reset_rd_data: got %h want 0", bus_rdata); end
        n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b want 0", irq); end
        rst = 1'b0;
        div_model = DIV0;
        clear_mon();
        mon_en = 1'b1;
        wait_cycles(2);
        bus_read(2'd1, r);
        n_tests++; if (r !== exp_status(0, 0, 0)) begin n_fail++; $display("FAIL reset_status: got %h want %h", r, exp_status(0, 0, 0)); end
        bus_read(2'd2, r);
        n_tests++; if (r !== 32'(DIV0)) begin n_fail++; $display("FAIL reset_baud: got %0d want %0d", r, DIV0); end
        bus_read(2'd0, r);
        n_tests++; if (r !== 32'd0) begin n_fail++; $display("FAIL txdata_read: got %h want 0", r); end
    endtask

    task automatic test_single_frame();
        logic [31:0] r;
        int n0;
        bus_write(2'd2, 32'd4, 4'b0011);
        div_model = 4;
        clear_mon();
        bus_write(2'd0, 32'hA5, 4'b0001);
        n0 = cyc;
        n_tests++; if (tx !== 1'b1) begin n_fail++; $display("FAIL frame_tx_at_write: got %b want 1", tx); end
        wait_until(n0 + 40);
        bus_read(2'd1, r);
        n_tests++; if (r !== exp_status(0, 1, 0)) begin n_fail++; $display("FAIL frame_last_stop_status: got %h want %h", r, exp_status(0, 1, 0)); end
        bus_read(2'd1, r);
        n_tests++; if (r !== exp_status(0, 0, 0)) begin n_fail++; $display("FAIL frame_done_status: got %h want %h", r, exp_status(0, 0, 0)); end
        n_tests++; if (rx_data.size() != 1 || rx_data[0] !== 8'hA5) begin n_fail++; $display("FAIL frame_byte: got %0d bytes first %h want 1 byte a5", rx_data.size(), (rx_data.size() > 0) ? rx_data[0] : 8'hxx); end
        n_tests++; if (rx_start.size() < 1 || rx_start[0] != n0 + 1) begin n_fail++; $display("FAIL frame_start_cycle: got %0d want %0d", (rx_start.size() > 0) ? rx_start[0] : -1, n0 + 1); end
        n_tests++; if (rx_bad != 0) begin n_fail++; $display("FAIL frame_timing: got %0d bad frames want 0", rx_bad); end
    endtask

    task automatic test_baud_reg();
        logic [31:0] r;
        int prev;
        bus_write(2'd2, 32'd0, 4'b0011);
        div_model = baud_after(div_model, 32'd0, 4'b0011);
        bus_read(2'd2, r);
        n_tests++; if (r !== 32'(div_model)) begin n_fail++; $display("FAIL baud_clamp_zero: got %0d want %0d", r, div_model); end
        bus_write(2'd2, 32'hFFFF_AB07, 4'b0010);
        div_model = baud_after(div_model, 32'hFFFF_AB07, 4'b0010);
        bus_read(2'd2, r);
        n_tests++; if (r !== 32'(div_model)) begin n_fail++; $display("FAIL baud_mask_hi: got %h want %h", r, div_model); end
        bus_write(2'd2, 32'h0000_0001, 4'b0001);
        div_model = baud_after(div_model, 32'h0000_0001, 4'b0001);
        bus_read(2'd2, r);
        n_tests++; if (r !== 32'(div_model)) begin n_fail++; $display("FAIL baud_mask_lo: got %h want %h", r, div_model); end
        prev = div_model;
        bus_write(2'd2, 32'd3, 4'b0011);
        div_model = baud_after(div_model, 32'd3, 4'b0011);
        n_tests++; if (bus_rdata !== 32'(prev)) begin n_fail++; $display("FAIL rd_data_hold: got %h want %h", bus_rdata, prev); end
        bus_read(2'd2, r);
        n_tests++; if (r !== 32'(div_model)) begin n_fail++; $display("FAIL baud_write: got %0d want %0d", r, div_model); end
    endtask

    task automatic test_overflow();
        logic [31:0] r;
        logic [7:0]  exp_q [$];
        logic [7:0]  b;
        int n0;
        bit ok;
        bus_write(2'd2, 32'd2, 4'b0011);
        div_model = 2;
        clear_mon();
        for (int j = 0; j < DEPTH + 1; j++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            bus_write(2'd0, {24'($urandom), b}, 4'b0001);
            if (j == 0) n0 = cyc;
        end
        bus_read(2'd1, r);
        n_tests++; if (r !== exp_status(DEPTH, 1, 0)) begin n_fail++; $display("FAIL ovf_all_accepted: got %h want %h", r, exp_status(DEPTH, 1, 0)); end
        bus_write(2'd0, 32'h5A, 4'b0001);
        bus_read(2'd1, r);
        n_tests++; if (r !== exp_status(DEPTH, 1, 1)) begin n_fail++; $display("FAIL ovf_set: got %h want %h", r, exp_status(DEPTH, 1, 1)); end
        bus_write(2'd1, 32'h8, 4'b0001);
        bus_read(2'd1, r);
        n_tests++; if (r !== exp_status(DEPTH, 1, 0)) begin n_fail++; $display("FAIL ovf_clear: got %h want %h", r, exp_status(DEPTH, 1, 0)); end
        wait_rx(DEPTH + 1, (DEPTH + 1) * 20 + 60, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL ovf_drain: got %0d bytes want %0d", rx_data.size(), DEPTH + 1); end
        for (int j = 0; j < DEPTH + 1; j++) begin
            n_tests++;
            if (j >= rx_data.size() || rx_data[j] !== exp_q[j]) begin
                n_fail++; $display("FAIL ovf_byte%0d: got %h want %h", j, (j < rx_data.size()) ? rx_data[j] : 8'hxx, exp_q[j]);
            end
        end
        n_tests++; if (rx_start.size() < 1 || rx_start[0] != n0 + 1) begin n_fail++; $display("FAIL ovf_first_pop: got %0d want %0d", (rx_start.size() > 0) ? rx_start[0] : -1, n0 + 1); end
        n_tests++; if (rx_bad != 0 || rx_data.size() != DEPTH + 1) begin n_fail++; $display("FAIL ovf_frames: got %0d bad, %0d bytes want 0 bad, %0d bytes", rx_bad, rx_data.size(), DEPTH + 1); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r;
        logic [7:0]  exp_q [$];
        logic [7:0]  b;
        int d;
        int n0;
        int k2;
        bit ok;
        d = $urandom_range(2, 5);
        bus_write(2'd2, 32'(d), 4'b0011);
        div_model = d;
        clear_mon();
        for (int j = 0; j < 3; j++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            bus_write(2'd0, {24'd0, b}, 4'b0001);
            if (j == 0) n0 = cyc;
        end
        for (int k = 0; k < 3; k++) begin
            k2 = 0;
            while (rx_start.size() <= k && k2 < 20 * d) begin @(posedge clk); #1; k2++; end
            bus_read(2'd1, r);
            n_tests++; if (r !== exp_status(2 - k, 1, 0)) begin n_fail++; $display("FAIL b2b_count%0d: got %h want %h", k, r, exp_status(2 - k, 1, 0)); end
        end
        wait_rx(3, 40 * d + 20, ok);
        for (int j = 0; j < 3; j++) begin
            n_tests++;
            if (j >= rx_data.size() || rx_data[j] !== exp_q[j]) begin
                n_fail++; $display("FAIL b2b_byte%0d: got %h want %h", j, (j < rx_data.size()) ? rx_data[j] : 8'hxx, exp_q[j]);
            end
        end
        n_tests++;
        if (rx_start.size() != 3 || rx_start[0] != n0 + 1 || rx_start[1] != n0 + 1 + 10 * d || rx_start[2] != n0 + 1 + 20 * d) begin
            n_fail++; $display("FAIL b2b_contiguous: got %0d starts want starts at %0d step %0d", rx_start.size(), n0 + 1, 10 * d);
        end
        n_tests++; if (rx_bad != 0) begin n_fail++; $display("FAIL b2b_timing: got %0d bad frames want 0", rx_bad); end
    endtask

    task automatic test_random();
        logic [31:0] r;
        logic [7:0]  exp_q [$];
        logic [7:0]  b;
        int d;
        int nb;
        bit ok;
        for (int it = 0; it < 4; it++) begin
            exp_q.delete();
            wait_cycles(2);
            d = $urandom_range(2, 6);
            bus_write(2'd2, {16'($urandom), 16'(d)}, 4'b0011);
            div_model = d;
            clear_mon();
            nb = $urandom_range(1, 5);
            for (int j = 0; j < nb; j++) begin
                if ($urandom_range(0, 2) == 0)
                    bus_write(2'd0, $urandom, {3'($urandom), 1'b0});
                b = 8'($urandom);
                exp_q.push_back(b);
                bus_write(2'd0, {24'($urandom), b}, {3'($urandom), 1'b1});
                wait_cycles($urandom_range(0, 3));
            end
            wait_rx(nb, nb * 10 * d + 40, ok);
            n_tests++; if (rx_data.size() != nb) begin n_fail++; $display("FAIL rand%0d_count: got %0d bytes want %0d", it, rx_data.size(), nb); end
            for (int j = 0; j < nb; j++) begin
                n_tests++;
                if (j >= rx_data.size() || rx_data[j] !== exp_q[j]) begin
                    n_fail++; $display("FAIL rand%0d_byte%0d: got %h want %h", it, j, (j < rx_data.size()) ? rx_data[j] : 8'hxx, exp_q[j]);
                end
            end
            n_tests++; if (rx_bad != 0) begin n_fail++; $display("FAIL rand%0d_timing: got %0d bad frames want 0", it, rx_bad); end
            wait_cycles(1);
            bus_read(2'd1, r);
            n_tests++; if (r !== exp_status(0, 0, 0)) begin n_fail++; $display("FAIL rand%0d_status: got %h want %h", it, r, exp_status(0, 0, 0)); end
        end
    endtask

    task automatic test_irq();
        logic [31:0] r;
        int n0;
        bit ok;
        bus_write(2'd2, 32'd2, 4'b0011);
        div_model = 2;
        clear_mon();
`ifdef UART_TX_IRQ_EN
        bus_write(2'd3, 32'd1, 4'b0001);
        bus_read(2'd3, r);
        n_tests++; if (r !== 32'd1) begin n_fail++; $display("FAIL ctrl_read: got %h want 1", r); end
        n_tests++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_idle: got %b want 1", irq); end
        bus_write(2'd0, 32'h3C, 4'b0001);
        n0 = cyc;
        n_tests++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_at_push: got %b want 1", irq); end
        wait_until(n0 + 10);
        n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_mid_frame: got %b want 0", irq); end
        wait_until(n0 + 21);
        n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_stop_end: got %b want 0", irq); end
        wait_until(n0 + 22);
        n_tests++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_after_stop: got %b want 1", irq); end
        bus_write(2'd3, 32'd0, 4'b0001);
`else
        bus_write(2'd3, 32'd1, 4'b0001);
        bus_read(2'd3, r);
        n_tests++; if (r !== 32'd0) begin n_fail++; $display("FAIL ctrl_read: got %h want 0", r); end
        bus_write(2'd0, 32'h3C, 4'b0001);
        n0 = cyc;
        for (int k = 0; k < 24; k++) begin
            n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_tied_c%0d: got %b want 0", cyc - n0, irq); end
            wait_cycles(1);
        end
`endif
        wait_rx(1, 40, ok);
        n_tests++; if (!ok || rx_data[0] !== 8'h3C) begin n_fail++; $display("FAIL irq_frame_byte: got %0d bytes want one 3c", rx_data.size()); end
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] r;
        int n0;
        wait_cycles(2);
        bus_write(2'd2, 32'd8, 4'b0011);
        div_model = 8;
        clear_mon();
        bus_write(2'd0, 32'h00, 4'b0001);
        n0 = cyc;
        bus_write(2'd0, $urandom, 4'b0001);
        bus_write(2'd0, $urandom, 4'b0001);
        wait_until(n0 + 12);
        #3;
        n_tests++; if (tx !== 1'b0) begin n_fail++; $display("FAIL pre_reset_tx: got %b want 0", tx); end
        mon_en = 1'b0;
        rst = 1'b1;
        #1;
        n_tests++; if (tx !== 1'b1) begin n_fail++; $display("FAIL async_reset_tx: got %b want 1", tx); end
        @(posedge clk); #1;
        rst = 1'b0;
        div_model = DIV0;
        clear_mon();
        mon_en = 1'b1;
        bus_read(2'd1, r);
        n_tests++; if (r !== exp_status(0, 0, 0)) begin n_fail++; $display("FAIL post_reset_status: got %h want %h", r, exp_status(0, 0, 0)); end
        bus_read(2'd2, r);
        n_tests++; if (r !== 32'(DIV0)) begin n_fail++; $display("FAIL post_reset_baud: got %0d want %0d", r, DIV0); end
        wait_cycles(20);
        n_tests++; if (rx_start.size() != 0 || tx !== 1'b1) begin n_fail++; $display("FAIL post_reset_idle: got %0d frames tx %b want 0 frames tx 1", rx_start.size(), tx); end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rx_bad  = 0;
        test_reset();
        test_single_frame();
        test_baud_reg();
        test_overflow();
        test_back_to_back();
        test_random();
        test_irq();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
